bram_be_pipe: RTL

- Parametrised single-port byte-enabled synchronous RAM; next generation of the CPU instruction/data RAM.
- Adds generic width and depth, a request/response handshake, selectable read latency, an out-of-range error response and a hardware zero-fill sweep after reset.
- Sits between the CPU fetch/LSU stage and the memory array; one request per cycle, responses in request order.

---
 rtl/bram_be_pipe_pkg.sv | 24 ++
 rtl/bram_be_core.sv | 81 ++++++++
 rtl/bram_be_pipe.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/bram_be_pipe_pkg.sv
// Shared types and helpers for the byte-enabled RAM block and its array core.
package bram_be_pipe_pkg;

    // Controller state: zero-fill sweep after reset, then normal service.
    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_DEPTH  = 512;
    localparam int DEF_ADDR_W = 32;

    // Number of byte lanes in a word.
    function automatic int f_bytes(input int data_w);
        return data_w / 8;
    endfunction

    // Address bits needed to select one of n items.
    function automatic int f_log2(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/bram_be_core.sv
// Raw byte-lane memory array: one byte-enabled write port and a registered
// read port. The read register loads either the addressed word or zero, and
// holds its value when no read is requested.
module bram_be_core
    import bram_be_pipe_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int NEG_EDGE = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_we,
    input  logic [DATA_W/8-1:0]      i_be,
    input  logic [$clog2(DEPTH)-1:0] i_idx,
    input  logic [DATA_W-1:0]        i_wdata,
    input  logic                     i_rd_en,
    input  logic                     i_rd_zero,
    output logic [DATA_W-1:0]        o_rdata
);
    localparam int BYTES = f_bytes(DATA_W);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;
    logic [DATA_W-1:0] w_rdata_nxt;

    // Next read-register value: array word, forced zero, or hold.
    always_comb begin
        w_rdata_nxt = r_rdata;
        if (i_rd_en) begin
            w_rdata_nxt = i_rd_zero ? '0 : r_mem[i_idx];
        end
    end

    generate
        if (NEG_EDGE != 0) begin : g_neg
            // Byte-lane array write on the falling edge.
            always_ff @(negedge clk) begin
                if (i_we) begin
                    for (int b = 0; b < BYTES; b++) begin
                        if (i_be[b]) begin
                            r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
                        end
                    end
                end
            end

            // Read register on the falling edge; cleared by reset.
            always_ff @(negedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_rdata <= '0;
                end else begin
                    r_rdata <= w_rdata_nxt;
                end
            end
        end else begin : g_pos
            // Byte-lane array write on the rising edge.
            always_ff @(posedge clk) begin
                if (i_we) begin
                    for (int b = 0; b < BYTES; b++) begin
                        if (i_be[b]) begin
                            r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
                        end
                    end
                end
            end

            // Read register on the rising edge; cleared by reset.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_rdata <= '0;
                end else begin
                    r_rdata <= w_rdata_nxt;
                end
            end
        end
    endgenerate

    assign o_rdata = r_rdata;

endmodule

// File: rtl/bram_be_pipe.sv
// Request/response front end for the byte-enabled RAM: zero-fill sweep after
// reset, range check, array port muxing and a 1- or 2-cycle response pipeline.
module bram_be_pipe
    import bram_be_pipe_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int READ_LAT = 1,
    parameter int NEG_EDGE = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [DATA_W/8-1:0] req_be,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                rsp_valid,
    output logic                rsp_we,
    output logic                rsp_err,
    output logic [DATA_W-1:0]   rsp_data,
    output logic                init_done
);
    localparam int BYTES = f_bytes(DATA_W);
    localparam int OFF_W = f_log2(BYTES);
    localparam int IDX_W = f_log2(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    // Control state plus the stage-0 response flags, all cleared by reset.
    typedef struct packed {
        state_t           state;
        logic [IDX_W-1:0] init_cnt;
        logic             ready;
        logic             init_done;
        logic             vld_p0;
        logic             we_p0;
        logic             err_p0;
    } ctl_t;

    ctl_t              r_ctl;
    ctl_t              w_ctl_nxt;
    logic [ADDR_W-1:0] w_word;
    logic [IDX_W-1:0]  w_idx;
    logic              w_err;
    logic              w_acc;
    logic              w_mem_we;
    logic [BYTES-1:0]  w_mem_be;
    logic [IDX_W-1:0]  w_mem_idx;
    logic [DATA_W-1:0] w_mem_wdata;
    logic              w_rd_en;
    logic              w_rd_zero;
    logic [DATA_W-1:0] w_rdata;

    // Any set address bit above the index field is out of range; the
    // byte-offset bits are dropped without an alignment check.
    assign w_word = req_addr >> OFF_W;
    assign w_idx  = w_word[IDX_W-1:0];
    assign w_err  = |(w_word >> IDX_W);
    assign w_acc  = req_valid & r_ctl.ready;

    // Next control state: sweep counter, INIT->RUN, stage-0 response flags.
    always_comb begin
        w_ctl_nxt        = r_ctl;
        w_ctl_nxt.vld_p0 = w_acc;
        w_ctl_nxt.we_p0  = w_acc & req_we;
        w_ctl_nxt.err_p0 = w_acc & w_err;
        case (r_ctl.state)
            INIT: begin
                w_ctl_nxt.init_cnt = r_ctl.init_cnt + 1'b1;
                if (r_ctl.init_cnt == LAST_IDX) begin
                    w_ctl_nxt.state     = RUN;
                    w_ctl_nxt.ready     = 1'b1;
                    w_ctl_nxt.init_done = 1'b1;
                end
            end
            RUN: begin
                w_ctl_nxt.ready     = 1'b1;
                w_ctl_nxt.init_done = 1'b1;
            end
        endcase
    end

    // Array port: the sweep owns it during INIT, accepted requests in RUN.
    // Writes and errors load zero into the read register so rsp_data is 0.
    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_be    = '0;
        w_mem_idx   = w_idx;
        w_mem_wdata = req_wdata;
        w_rd_en     = 1'b0;
        w_rd_zero   = 1'b0;
        if (r_ctl.state == INIT) begin
            w_mem_we    = 1'b1;
            w_mem_be    = '1;
            w_mem_idx   = r_ctl.init_cnt;
            w_mem_wdata = '0;
        end else if (w_acc) begin
            w_mem_we  = req_we & ~w_err;
            w_mem_be  = req_be;
            w_rd_en   = 1'b1;
            w_rd_zero = req_we | w_err;
        end
    end

    bram_be_core #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .NEG_EDGE (NEG_EDGE)
    ) u_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_we      (w_mem_we),
        .i_be      (w_mem_be),
        .i_idx     (w_mem_idx),
        .i_wdata   (w_mem_wdata),
        .i_rd_en   (w_rd_en),
        .i_rd_zero (w_rd_zero),
        .o_rdata   (w_rdata)
    );

    generate
        if (NEG_EDGE != 0) begin : g_neg
            // Control and stage-0 response flags on the falling edge.
            always_ff @(negedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_ctl <= '0;
                end else begin
                    r_ctl <= w_ctl_nxt;
                end
            end
        end else begin : g_pos
            // Control and stage-0 response flags on the rising edge.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_ctl <= '0;
                end else begin
                    r_ctl <= w_ctl_nxt;
                end
            end
        end
    endgenerate

    generate
        if (READ_LAT == 2) begin : g_lat2
            logic              r_vld_p1;
            logic              r_we_p1;
            logic              r_err_p1;
            logic [DATA_W-1:0] r_data_p1;
            logic [DATA_W-1:0] w_data_p1_nxt;

            // Stage-1 data captures the read register only behind a valid
            // response, so idle cycles hold the last response data.
            assign w_data_p1_nxt = r_ctl.vld_p0 ? w_rdata : r_data_p1;

            if (NEG_EDGE != 0) begin : g_neg
                // Extra output stage on the falling edge.
                always_ff @(negedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        r_vld_p1  <= 1'b0;
                        r_we_p1   <= 1'b0;
                        r_err_p1  <= 1'b0;
                        r_data_p1 <= '0;
                    end else begin
                        r_vld_p1  <= r_ctl.vld_p0;
                        r_we_p1   <= r_ctl.we_p0;
                        r_err_p1  <= r_ctl.err_p0;
                        r_data_p1 <= w_data_p1_nxt;
                    end
                end
            end else begin : g_pos
                // Extra output stage on the rising edge.
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        r_vld_p1  <= 1'b0;
                        r_we_p1   <= 1'b0;
                        r_err_p1  <= 1'b0;
                        r_data_p1 <= '0;
                    end else begin
                        r_vld_p1  <= r_ctl.vld_p0;
                        r_we_p1   <= r_ctl.we_p0;
                        r_err_p1  <= r_ctl.err_p0;
                        r_data_p1 <= w_data_p1_nxt;
                    end
                end
            end

            assign rsp_valid = r_vld_p1;
            assign rsp_we    = r_we_p1;
            assign rsp_err   = r_err_p1;
            assign rsp_data  = r_data_p1;
        end else begin : g_lat1
            assign rsp_valid = r_ctl.vld_p0;
            assign rsp_we    = r_ctl.we_p0;
            assign rsp_err   = r_ctl.err_p0;
            assign rsp_data  = w_rdata;
        end
    endgenerate

    assign req_ready = r_ctl.ready;
    assign init_done = r_ctl.init_done;

endmodule
